// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: packs FIFO read bytes into PACK-lane words with flush and ready/valid output
module fifo_rd_packer #(
  parameter int D_WIDTH = 8,
  parameter int PACK = 4
) (
  input  logic                    rd_clk,
  input  logic                    reset,
  input  logic                    empty_i,
  input  logic [D_WIDTH-1:0]      rd_data_i,
  output logic                    rd_en_o,
  input  logic                    flush_i,
  output logic [D_WIDTH*PACK-1:0] out_data_o,
  output logic [PACK-1:0]         out_keep_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [15:0]             word_count_o
);
  localparam int CW = $clog2(PACK + 1);
  localparam int AW = $clog2(PACK);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_d;
  logic [D_WIDTH-1:0] acc [PACK];
  logic [CW-1:0] cnt, cnt_eff;
  logic inflight, slot_free, load;
  logic [D_WIDTH*PACK-1:0] word;
  logic [PACK-1:0] keep;
  assign slot_free = !out_valid_o || out_ready_i;
  assign load = slot_free && cnt_eff != '0 && (cnt_eff == CW'(PACK) || (state == FLUSH && !inflight));
  assign rd_en_o = reset && !empty_i && state == RUN && cnt_eff < CW'(PACK);
  // candidate output word: accumulated lanes plus the byte landing this cycle, unused lanes zeroed
  always_comb begin
    cnt_eff = cnt + CW'(inflight);
    word = '0;
    keep = '0;
    for (int i = 0; i < PACK; i++) begin
      keep[i] = CW'(i) < cnt_eff;
      word[i*D_WIDTH +: D_WIDTH] = !keep[i] ? '0 : (inflight && CW'(i) == cnt) ? rd_data_i : acc[i];
    end
  end
  // flush sequencing: leave FLUSH once nothing is in flight and any partial word has a free slot
  always_comb begin
    state_d = state == RUN ? (flush_i ? FLUSH : RUN) : (!inflight && (cnt == '0 || slot_free)) ? RUN : FLUSH;
  end
  // state register
  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) state <= RUN;
    else state <= state_d;
  end
  // lane capture, output register and accepted-word counter
  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      inflight <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o <= '0;
      out_keep_o <= '0;
      word_count_o <= '0;
      for (int i = 0; i < PACK; i++) acc[i] <= '0;
    end else begin
      inflight <= rd_en_o;
      cnt <= load ? '0 : cnt_eff;
      if (inflight) acc[cnt[AW-1:0]] <= rd_data_i;
      if (load) begin
        out_data_o <= word;
        out_keep_o <= keep;
      end
      out_valid_o <= load || (out_valid_o && !out_ready_i);
      if (out_valid_o && out_ready_i) word_count_o <= word_count_o + 16'd1;
    end
  end
endmodule
